// File: rtl/lstm_seq_ctrl.sv
// Sequencer around a combinational LSTM cell: holds (c, h), feeds the cell one
// sample per timestep, waits a fixed settle time, captures the result and emits it.
module lstm_seq_ctrl #(
   parameter int DATA_WIDTH    = 16,
   parameter int FRACT_WIDTH   = 8,
   parameter int SEQ_LEN_W     = 8,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [SEQ_LEN_W-1:0]  seq_len,
   input  logic [DATA_WIDTH-1:0] c_init,
   input  logic [DATA_WIDTH-1:0] h_init,
   input  logic                  x_valid,
   input  logic [DATA_WIDTH-1:0] x_data,
   output logic                  x_ready,
   output logic [DATA_WIDTH-1:0] cell_x,
   output logic [DATA_WIDTH-1:0] cell_c_in,
   output logic [DATA_WIDTH-1:0] cell_h_in,
   input  logic [DATA_WIDTH-1:0] cell_c_out,
   input  logic [DATA_WIDTH-1:0] cell_h_out,
   output logic                  h_valid,
   output logic [DATA_WIDTH-1:0] h_data,
   output logic [DATA_WIDTH-1:0] c_data,
   output logic                  h_last,
   input  logic                  h_ready,
   output logic                  busy,
   output logic                  done
);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || FRACT_WIDTH > DATA_WIDTH) begin : g_param_check
      $error("lstm_seq_ctrl: SETTLE_CYCLES must be 1..15 and FRACT_WIDTH <= DATA_WIDTH");
   end

   typedef enum logic [1:0] {IDLE, WAIT_X, SETTLE, OUTPUT} state_e;

   localparam logic [3:0]           SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [SEQ_LEN_W-1:0] LEN_ONE     = SEQ_LEN_W'(1);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] c_q, c_d;
   logic [DATA_WIDTH-1:0] h_q, h_d;
   logic [DATA_WIDTH-1:0] x_q, x_d;
   logic [DATA_WIDTH-1:0] hout_q, hout_d;
   logic [DATA_WIDTH-1:0] cout_q, cout_d;
   logic [SEQ_LEN_W-1:0]  len_q, len_d;
   logic [SEQ_LEN_W-1:0]  step_q, step_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  last_q, last_d;
   logic                  done_q, done_d;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d = state_q;
      c_d     = c_q;
      h_d     = h_q;
      x_d     = x_q;
      hout_d  = hout_q;
      cout_d  = cout_q;
      len_d   = len_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (seq_len != '0) begin
                  c_d     = c_init;
                  h_d     = h_init;
                  len_d   = seq_len;
                  step_d  = '0;
                  state_d = WAIT_X;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         WAIT_X: begin
            if (x_valid) begin
               x_d     = x_data;
               cnt_d   = SETTLE_LOAD;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               c_d     = cell_c_out;
               h_d     = cell_h_out;
               cout_d  = cell_c_out;
               hout_d  = cell_h_out;
               last_d  = (step_q == len_q - LEN_ONE);
               state_d = OUTPUT;
            end
         end
         OUTPUT: begin
            if (h_ready) begin
               step_d = step_q + LEN_ONE;
               if (last_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT_X;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         c_q     <= '0;
         h_q     <= '0;
         x_q     <= '0;
         hout_q  <= '0;
         cout_q  <= '0;
         len_q   <= '0;
         step_q  <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         h_q     <= h_d;
         x_q     <= x_d;
         hout_q  <= hout_d;
         cout_q  <= cout_d;
         len_q   <= len_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   // Handshake outputs decode from state only, never from the partner's valid/ready.
   assign x_ready   = (state_q == WAIT_X);
   assign h_valid   = (state_q == OUTPUT);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign h_last    = last_q;
   assign h_data    = hout_q;
   assign c_data    = cout_q;
   assign cell_x    = x_q;
   assign cell_c_in = c_q;
   assign cell_h_in = h_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Scoreboard bench for lstm_seq_ctrl with a behavioural cell (c_out = c_in + x, h_out = x).
module tb_lstm_seq_ctrl;

   localparam int DW = 16;
   localparam int LW = 8;

   typedef struct {
      logic [DW-1:0] h;
      logic [DW-1:0] c;
      logic          last;
   } exp_t;

   logic          clk, rst, start, x_valid, x_ready, h_valid, h_last, h_ready, busy, done;
   logic [LW-1:0] seq_len;
   logic [DW-1:0] c_init, h_init, x_data, cell_x, cell_c_in, cell_h_in;
   logic [DW-1:0] cell_c_out, cell_h_out, h_data, c_data;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_due = 0;
   exp_t sb_q[$];

   lstm_seq_ctrl #(.DATA_WIDTH(DW), .FRACT_WIDTH(8), .SEQ_LEN_W(LW), .SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .c_init(c_init), .h_init(h_init),
      .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
      .cell_x(cell_x), .cell_c_in(cell_c_in), .cell_h_in(cell_h_in),
      .cell_c_out(cell_c_out), .cell_h_out(cell_h_out),
      .h_valid(h_valid), .h_data(h_data), .c_data(c_data), .h_last(h_last), .h_ready(h_ready),
      .busy(busy), .done(done)
   );

   assign cell_c_out = cell_c_in + cell_x;
   assign cell_h_out = cell_x;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each accepted output, checks hold-under-backpressure and done.
   initial begin : monitor
      exp_t          e;
      logic          pend = 1'b0;
      logic [DW-1:0] p_h  = '0;
      logic [DW-1:0] p_c  = '0;
      logic          p_l  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               check("hold_valid", 64'(h_valid), 64'(1));
               check("hold_h", 64'(h_data), 64'(p_h));
               check("hold_c", 64'(c_data), 64'(p_c));
               check("hold_last", 64'(h_last), 64'(p_l));
            end
            if (done) begin
               check("done_expected", 64'(done_due > 0), 64'(1));
               if (done_due > 0) done_due--;
            end
            if (h_valid && h_ready) begin
               if (sb_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_empty: got output h=0x%0h required none", h_data);
               end else begin
                  e = sb_q.pop_front();
                  check("out_h", 64'(h_data), 64'(e.h));
                  check("out_c", 64'(c_data), 64'(e.c));
                  check("out_last", 64'(h_last), 64'(e.last));
                  if (e.last) done_due++;
               end
               pend = 1'b0;
            end else if (h_valid) begin
               pend = 1'b1;
               p_h  = h_data;
               p_c  = c_data;
               p_l  = h_last;
            end else begin
               pend = 1'b0;
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_x_ready"}, 64'(x_ready), 64'(0));
      check({tag, "_h_valid"}, 64'(h_valid), 64'(0));
      check({tag, "_h_last"}, 64'(h_last), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_h_data"}, 64'(h_data), 64'(0));
      check({tag, "_c_data"}, 64'(c_data), 64'(0));
      check({tag, "_cell_x"}, 64'(cell_x), 64'(0));
      check({tag, "_cell_c_in"}, 64'(cell_c_in), 64'(0));
      check({tag, "_cell_h_in"}, 64'(cell_h_in), 64'(0));
   endtask

   // mode: 0 random gaps/backpressure, 1 fixed x with latency checks, 2 long backpressure,
   //       3 start pulsed mid-sequence, 4 reset during SETTLE of step 2
   task automatic run_seq(input int len, input logic [DW-1:0] c0, input logic [DW-1:0] h0, input int mode);
      logic [DW-1:0] xs[$];
      logic [DW-1:0] c_m, h_m, x;
      exp_t          e;
      logic          acc;
      int            w;
      c_m = c0;
      for (int i = 0; i < len; i++) begin
         x = (mode == 1) ? DW'(16 * (i + 1)) : DW'($urandom);
         xs.push_back(x);
         c_m    = c_m + x;
         e.h    = x;
         e.c    = c_m;
         e.last = (i == len - 1);
         sb_q.push_back(e);
      end

      seq_len = LW'(len);
      c_init  = c0;
      h_init  = h0;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'(1));

      c_m = c0;
      h_m = h0;
      for (int i = 0; i < len; i++) begin
         if (mode == 0) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
               h_ready = ($urandom_range(0, 3) != 0);
            end
         end
         x_valid = 1'b1;
         x_data  = xs[i];
         acc     = 1'b0;
         w       = 0;
         while (!acc && w < 100) begin
            @(negedge clk);
            acc = x_ready;
            @(posedge clk); #1;
            w++;
            if (mode == 0 && !acc) h_ready = ($urandom_range(0, 3) != 0);
         end
         x_valid = 1'b0;
         if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no x_ready in 100 cycles, required accept of step %0d", i);
            sb_q.delete();
            return;
         end

         if (mode == 1) begin
            for (int k = 1; k <= 3; k++) begin
               @(negedge clk);
               check("lat_h_valid", 64'(h_valid), 64'(k == 3));
               check("lat_cell_c_in", 64'(cell_c_in), 64'((k == 3) ? DW'(c_m + xs[i]) : c_m));
               if (k == 1) begin
                  check("lat_cell_x", 64'(cell_x), 64'(xs[i]));
                  check("lat_cell_h_in", 64'(cell_h_in), 64'(h_m));
               end
            end
            @(posedge clk); #1;
         end else if (mode == 2 && i == 1) begin
            h_ready = 1'b0;
            x_valid = 1'b1;
            x_data  = 16'hBEEF;
            w = 0;
            while (!h_valid && w < 20) begin
               @(posedge clk); #1;
               w++;
            end
            check("bp_valid_seen", 64'(h_valid), 64'(1));
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("bp_x_ready", 64'(x_ready), 64'(0));
               check("bp_h_valid", 64'(h_valid), 64'(1));
            end
            @(posedge clk); #1;
            h_ready = 1'b1;
            x_valid = 1'b0;
         end else if (mode == 3 && i == 0) begin
            seq_len = LW'(1);
            c_init  = 16'hDEAD;
            h_init  = 16'hBEEF;
            start   = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("midstart_busy", 64'(busy), 64'(1));
         end else if (mode == 4 && i == 1) begin
            rst = 1'b1;
            @(posedge clk); #1;
            check_all_zero("abort");
            rst = 1'b0;
            sb_q.delete();
            repeat (3) begin
               @(posedge clk); #1;
               check("abort_busy", 64'(busy), 64'(0));
               check("abort_x_ready", 64'(x_ready), 64'(0));
            end
            check("abort_no_done", 64'(done_due), 64'(0));
            return;
         end
         c_m = c_m + xs[i];
         h_m = xs[i];
      end

      h_ready = 1'b1;
      w = 0;
      while ((sb_q.size() != 0 || busy) && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      check("seq_complete", 64'(w < 200), 64'(1));
      @(negedge clk);
      @(posedge clk); #1;
      check("done_seen", 64'(done_due), 64'(0));
   endtask

   initial begin : stimulus
      rst     = 1'b1;
      start   = 1'b0;
      seq_len = '0;
      c_init  = '0;
      h_init  = '0;
      x_valid = 1'b0;
      x_data  = '0;
      h_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      run_seq(3, 16'h0100, 16'h0000, 1);
      run_seq(4, DW'($urandom), DW'($urandom), 2);

      // Zero-length sequence: a single done pulse, never busy.
      seq_len = '0;
      start   = 1'b1;
      done_due++;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("zero_len_done", 64'(done), 64'(k == 0));
         check("zero_len_busy", 64'(busy), 64'(0));
         check("zero_len_x_ready", 64'(x_ready), 64'(0));
      end
      @(posedge clk); #1;
      check("zero_len_done_count", 64'(done_due), 64'(0));

      run_seq(3, DW'($urandom), DW'($urandom), 3);
      run_seq(4, DW'($urandom), DW'($urandom), 4);
      run_seq(1, DW'($urandom), DW'($urandom), 0);
      for (int r = 0; r < 6; r++) begin
         run_seq($urandom_range(1, 6), DW'($urandom), DW'($urandom), 0);
      end
      run_seq(255, DW'($urandom), DW'($urandom), 0);

      check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lstm_seq_ctrl.md
Name: lstm_seq_ctrl

Overview:
- Sequencer that sits directly upstream of, and around, the combinational LSTM cell.
- It accepts a stream of input samples X over a valid/ready handshake and holds the recurrent state (c, h) in registers.
- It drives the cell's X/c_in/h_in inputs, waits a fixed settle time, then captures c_out/h_out as the next state.
- It emits one h per timestep downstream and flags the last step of a sequence of programmable length.

Parameters:
- DATA_WIDTH, 16, width of X, c, h (signed fixed point)
- FRACT_WIDTH, 8, fractional bits (informational; no arithmetic in this block)
- SEQ_LEN_W, 8, width of the sequence-length field
- SETTLE_CYCLES, 2, cycles the cell inputs are held stable before capture; legal range 1 to 15

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a sequence; sampled only in IDLE
- seq_len  in  SEQ_LEN_W  number of timesteps; sampled with start
- c_init  in  DATA_WIDTH  initial cell state; sampled with start
- h_init  in  DATA_WIDTH  initial hidden state; sampled with start
- x_valid  in  1  input sample valid
- x_data  in  DATA_WIDTH  input sample
- x_ready  out  1  block can accept a sample
- cell_x  out  DATA_WIDTH  to cell X (registered)
- cell_c_in  out  DATA_WIDTH  to cell c_in (registered)
- cell_h_in  out  DATA_WIDTH  to cell h_in (registered)
- cell_c_out  in  DATA_WIDTH  from cell c_out
- cell_h_out  in  DATA_WIDTH  from cell h_out
- h_valid  out  1  output step valid
- h_data  out  DATA_WIDTH  hidden state for this step
- c_data  out  DATA_WIDTH  cell state for this step
- h_last  out  1  this is the final step of the sequence; qualified by h_valid
- h_ready  in  1  downstream accepts the output
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of sequence

Behaviour:
- Reset:
  - State goes to IDLE.
  - x_ready, h_valid, h_last, busy, done are 0.
  - h_data, c_data, cell_x, cell_c_in, cell_h_in, and the step counter are 0.
  - A reset mid-sequence aborts it: no done pulse, and any pending output is dropped.
- States: IDLE, WAIT_X, SETTLE, OUTPUT.
- IDLE:
  - On start with seq_len != 0: load c_reg = c_init, h_reg = h_init, len_reg = seq_len, step = 0; go to WAIT_X.
  - On start with seq_len == 0: pulse done on the next cycle and stay in IDLE.
  - x_valid is ignored in IDLE.
- start is ignored outside IDLE. seq_len, c_init and h_init are not sampled again until the next start.
- WAIT_X:
  - x_ready = 1.
  - On x_valid & x_ready: load cell_x = x_data, load settle counter = SETTLE_CYCLES - 1, go to SETTLE.
- SETTLE:
  - x_ready = 0. cell_x, cell_c_in and cell_h_in are held constant.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, capture c_reg = cell_c_out, h_reg = cell_h_out, c_data = cell_c_out, h_data = cell_h_out, and h_last = (step == len_reg - 1); go to OUTPUT.
- Timing:
  - Sample accepted at edge T; capture at edge T + SETTLE_CYCLES.
  - h_valid is first high in the cycle after the capture edge.
  - Accept-to-valid latency is SETTLE_CYCLES + 1 cycles.
- cell_c_in and cell_h_in are driven directly from c_reg and h_reg, so the new state reaches the cell on the cycle after capture.
- OUTPUT:
  - h_valid = 1. h_data, c_data and h_last stay stable until accepted.
  - On h_ready: step increments. If h_last, pulse done for one cycle (registered, same edge as the exit) and go to IDLE. Otherwise go to WAIT_X.
  - No new sample is accepted until the output is consumed (no overlap).
- h_valid must not depend combinationally on h_ready. x_ready must not depend combinationally on x_valid.
- The step counter is SEQ_LEN_W wide. seq_len = 2^SEQ_LEN_W - 1 is the maximum; the counter never wraps within a sequence.
- Downstream throughput is at most 1 step per SETTLE_CYCLES + 2 cycles.

Test Plan:
- Bench cell model for all scenarios: c_out = c_in + x, h_out = x.
- Basic: rst 2 cycles, then start with seq_len = 3, c_init = 0x0100, h_init = 0. Send x = 0x0010, 0x0020, 0x0030 with h_ready tied to 1.
  - Outputs in order: (h, c) = (0x0010, 0x0110), (0x0020, 0x0130), (0x0030, 0x0160).
  - h_last is set only on the third output; one done pulse follows it.
- Latency: with SETTLE_CYCLES = 2, x accepted at cycle 10 -> h_valid first high at cycle 13.
  - cell_x = x from cycle 11.
  - cell_c_in is updated at cycle 13.
- Backpressure: hold h_ready = 0 for 5 cycles during OUTPUT.
  - h_valid, h_data, c_data stay constant and x_ready stays 0.
  - x_valid asserted meanwhile is not accepted.
  - On release, the sequence continues correctly.
- Edge cases:
  - start with seq_len = 0 -> done pulse the next cycle, busy never rises, x_ready stays 0.
  - start asserted mid-sequence -> ignored; len_reg unchanged.
- Reset mid-op: assert rst during SETTLE of step 2 of 4.
  - Next cycle: all outputs 0, IDLE, no done pulse.
  - A new start with seq_len = 1 then completes normally.
